timer_dev: RTL and testbench

- 16-bit programmable timer with prescaler, compare match and a level interrupt request.
- Sits as a responder on one device_mux slave port, alongside the UART and LED devices. It answers TG68 bus cycles that the mux routes to it.
- Its irq output is the first real source for the CPU interrupt level, which is tied to 3'b111 today.

---
 rtl/timer_pkg.sv | 55 +++++
 rtl/timer_prescaler.sv | 30 +++
 rtl/timer_dev.sv | 141 ++++++++++++++
 tb/tb_timer_dev.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer device: register offsets, bit indices,
// register-select decode and byte-lane merge helper.
package timer_pkg;

  // Byte offsets of the word registers inside the device window
  localparam logic [7:0] TMR_CTRL    = 8'h00;
  localparam logic [7:0] TMR_STATUS  = 8'h02;
  localparam logic [7:0] TMR_PRESC   = 8'h04;
  localparam logic [7:0] TMR_COUNT   = 8'h06;
  localparam logic [7:0] TMR_COMPARE = 8'h08;

  // CTRL bit indices
  localparam int EN         = 0;
  localparam int IRQ_EN     = 1;
  localparam int AUTORELOAD = 2;

  // STATUS bit index
  localparam int MATCH = 0;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_STATUS,
    SEL_PRESC,
    SEL_COUNT,
    SEL_COMPARE,
    SEL_NONE
  } reg_sel_t;

  // Word decode: addr[0] is ignored, unknown offsets map to SEL_NONE
  function automatic reg_sel_t decode_sel(input logic [7:0] a);
    reg_sel_t s;
    case ({a[7:1], 1'b0})
      TMR_CTRL:    s = SEL_CTRL;
      TMR_STATUS:  s = SEL_STATUS;
      TMR_PRESC:   s = SEL_PRESC;
      TMR_COUNT:   s = SEL_COUNT;
      TMR_COMPARE: s = SEL_COMPARE;
      default:     s = SEL_NONE;
    endcase
    return s;
  endfunction

  // Replace the strobed byte lanes of old_val with the matching lanes of wdata
  function automatic logic [15:0] lane_merge(input logic [15:0] old_val,
                                             input logic [15:0] wdata,
                                             input logic        hi,
                                             input logic        lo);
    logic [15:0] r;
    r = old_val;
    if (hi) r[15:8] = wdata[15:8];
    if (lo) r[7:0]  = wdata[7:0];
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: down-counter producing a one-clock tick every presc+1 clocks
// while enabled. The presc input is the value PRESC will hold after this
// edge, so a load picks up freshly written data on the same edge.
module timer_prescaler #(
  parameter logic [15:0] PRESC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] presc,
  output logic        tick
);

  logic [15:0] pcnt_reg;

  assign tick = en & (pcnt_reg == 16'h0000);

  // Reload on write, while disabled (hold at PRESC) or on terminal count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_reg <= PRESC_RESET;
    end else if (load || !en || tick) begin
      pcnt_reg <= presc;
    end else begin
      pcnt_reg <= pcnt_reg - 16'd1;
    end
  end

endmodule

// File: rtl/timer_dev.sv
// 16-bit programmable timer on a device_mux slave port: one-wait-state bus
// handshake, byte-lane register file, prescaled counter with compare match
// and a registered level interrupt.
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [15:0] PRESC_RESET   = 16'h0000,
  parameter logic [15:0] COMPARE_RESET = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_write,
  output logic [15:0] data_read,
  input  logic [7:0]  addr,
  input  logic        uds,
  input  logic        lds,
  input  logic        rw,
  output logic        ack,
  output logic        irq
);

  logic        ack_reg;
  logic [15:0] data_read_reg;
  logic        irq_reg;
  logic [2:0]  ctrl_reg;
  logic        match_reg;
  logic [15:0] presc_reg;
  logic [15:0] count_reg;
  logic [15:0] compare_reg;

  logic        strobe;
  logic        commit;
  logic        wr_en;
  reg_sel_t    sel;
  logic [15:0] read_value;
  logic [15:0] presc_next;
  logic [15:0] count_next;
  logic [15:0] count_inc;
  logic        tick;
  logic        hit;
  logic        status_clr;

  // Bus qualification: an access commits only on the edge ack rises
  assign strobe = uds | lds;
  assign commit = strobe & ~ack_reg;
  assign wr_en  = commit & ~rw;
  assign sel    = decode_sel(addr);

  // Read data mux; unmapped offsets read as zero
  always_comb begin
    read_value = 16'h0000;
    case (sel)
      SEL_CTRL:    read_value = {13'h0000, ctrl_reg};
      SEL_STATUS:  read_value = {15'h0000, match_reg};
      SEL_PRESC:   read_value = presc_reg;
      SEL_COUNT:   read_value = count_reg;
      SEL_COMPARE: read_value = compare_reg;
      default:     read_value = 16'h0000;
    endcase
  end

  // PRESC value after this edge, also fed to the prescaler for its reload
  always_comb begin
    presc_next = presc_reg;
    if (wr_en && sel == SEL_PRESC) begin
      presc_next = lane_merge(presc_reg, data_write, uds, lds);
    end
  end

  timer_prescaler #(
    .PRESC_RESET (PRESC_RESET)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ctrl_reg[EN]),
    .load    (wr_en && sel == SEL_PRESC),
    .presc   (presc_next),
    .tick    (tick)
  );

  assign count_inc  = count_reg + 16'd1;
  assign hit        = tick & (count_inc == compare_reg);
  assign status_clr = wr_en & (sel == SEL_STATUS) & lds & data_write[MATCH];

  // Counter next value: tick advances, a bus write to COUNT overrides it
  always_comb begin
    count_next = count_reg;
    if (tick) begin
      count_next = (hit && ctrl_reg[AUTORELOAD]) ? 16'h0000 : count_inc;
    end
    if (wr_en && sel == SEL_COUNT) begin
      count_next = lane_merge(count_reg, data_write, uds, lds);
    end
  end

  // Bus handshake: ack rises one edge after strobe, drops once strobes go low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_reg       <= 1'b0;
      data_read_reg <= 16'h0000;
    end else if (commit) begin
      ack_reg       <= 1'b1;
      data_read_reg <= read_value;
    end else if (!strobe) begin
      ack_reg       <= 1'b0;
    end
  end

  // Register file, counter, match flag and registered interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_reg    <= 3'b000;
      match_reg   <= 1'b0;
      presc_reg   <= PRESC_RESET;
      count_reg   <= 16'h0000;
      compare_reg <= COMPARE_RESET;
      irq_reg     <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      count_reg <= count_next;
      irq_reg   <= match_reg & ctrl_reg[IRQ_EN];
      if (wr_en && sel == SEL_CTRL && lds) begin
        ctrl_reg <= data_write[2:0];
      end
      if (wr_en && sel == SEL_COMPARE) begin
        compare_reg <= lane_merge(compare_reg, data_write, uds, lds);
      end
      // A match set on the same edge as a clear takes priority
      if (hit) begin
        match_reg <= 1'b1;
      end else if (status_clr) begin
        match_reg <= 1'b0;
      end
    end
  end

  assign ack       = ack_reg;
  assign data_read = data_read_reg;
  assign irq       = irq_reg;

endmodule

// File: tb/tb_timer_dev.sv
// Testbench for timer_dev: directed scenarios followed by random bus traffic,
// all checked against a clock-by-clock behavioural model of the timer.
module tb_timer_dev;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_write = 16'h0000;
  logic [15:0] data_read;
  logic [7:0]  addr = 8'h00;
  logic        uds = 1'b0;
  logic        lds = 1'b0;
  logic        rw = 1'b1;
  logic        ack;
  logic        irq;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  logic [2:0]  m_ctrl;
  logic        m_match;
  logic        m_irq;
  logic [15:0] m_presc;
  logic [15:0] m_pcnt;
  logic [15:0] m_count;
  logic [15:0] m_cmp;

  timer_dev dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_write (data_write),
    .data_read  (data_read),
    .addr       (addr),
    .uds        (uds),
    .lds        (lds),
    .rw         (rw),
    .ack        (ack),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_ctrl  = 3'b000;
    m_match = 1'b0;
    m_irq   = 1'b0;
    m_presc = 16'h0000;
    m_pcnt  = 16'h0000;
    m_count = 16'h0000;
    m_cmp   = 16'hFFFF;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                        input logic u, input logic l);
    logic [15:0] r;
    r = o;
    if (u) r[15:8] = d[15:8];
    if (l) r[7:0]  = d[7:0];
    return r;
  endfunction

  function automatic logic [15:0] m_read(input logic [7:0] a);
    logic [7:0] off;
    off = {a[7:1], 1'b0};
    if (off == TMR_CTRL)    return {13'h0000, m_ctrl};
    if (off == TMR_STATUS)  return {15'h0000, m_match};
    if (off == TMR_PRESC)   return m_presc;
    if (off == TMR_COUNT)   return m_count;
    if (off == TMR_COMPARE) return m_cmp;
    return 16'h0000;
  endfunction

  // One clock edge of the reference timer, with an optional bus write committing on it
  task automatic edge_step(input logic wr, input logic [7:0] a, input logic [15:0] d,
                           input logic u, input logic l);
    logic [7:0]  off;
    logic        en;
    logic        tick;
    logic        set;
    logic        new_irq;
    logic [15:0] pnew;
    logic [15:0] n;
    logic [15:0] old_count;
    @(posedge clk);
    off       = {a[7:1], 1'b0};
    en        = m_ctrl[0];
    tick      = en && (m_pcnt == 16'h0000);
    new_irq   = m_match & m_ctrl[1];
    old_count = m_count;
    set       = 1'b0;
    pnew      = (wr && off == TMR_PRESC) ? merge(m_presc, d, u, l) : m_presc;
    if ((wr && off == TMR_PRESC) || !en || tick) m_pcnt = pnew;
    else m_pcnt = m_pcnt - 16'd1;
    if (tick) begin
      n = m_count + 16'd1;
      if (n == m_cmp) begin
        set = 1'b1;
        m_count = m_ctrl[2] ? 16'h0000 : n;
      end else begin
        m_count = n;
      end
    end
    if (wr && off == TMR_COUNT) m_count = merge(old_count, d, u, l);
    if (set) m_match = 1'b1;
    else if (wr && off == TMR_STATUS && l && d[0]) m_match = 1'b0;
    if (wr && off == TMR_CTRL && l) m_ctrl = d[2:0];
    if (wr && off == TMR_COMPARE) m_cmp = merge(m_cmp, d, u, l);
    m_presc = pnew;
    m_irq   = new_irq;
    #1;
    chk("irq", {15'h0000, irq}, {15'h0000, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) edge_step(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
  endtask

  // Full bus access: strobe, commit edge, optional extra held edges, release edge
  task automatic access(input logic wr, input logic [7:0] a, input logic [15:0] d,
                        input logic u, input logic l, input int hold,
                        output logic [15:0] rdv);
    logic [15:0] exp;
    chk("ack_idle", {15'h0000, ack}, 16'h0000);
    addr = a; rw = ~wr; data_write = d; uds = u; lds = l;
    exp = m_read(a);
    edge_step(wr, a, d, u, l);
    chk("ack_rise", {15'h0000, ack}, 16'h0001);
    if (!wr) chk("read_data", data_read, exp);
    for (int i = 1; i < hold; i++) begin
      edge_step(1'b0, a, d, u, l);
      chk("ack_hold", {15'h0000, ack}, 16'h0001);
    end
    uds = 1'b0; lds = 1'b0;
    edge_step(1'b0, a, d, 1'b0, 1'b0);
    chk("ack_fall", {15'h0000, ack}, 16'h0000);
    rdv = data_read;
    $display("%0t %s addr=0x%h wdata=0x%h uds=%0d lds=%0d hold=%0d rdata=0x%h",
             $time, wr ? "WR" : "RD", a, d, u, l, hold, rdv);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [15:0] d);
    logic [15:0] v;
    access(1'b1, a, d, 1'b1, 1'b1, 1, v);
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [15:0] v);
    access(1'b0, a, 16'h0000, 1'b1, 1'b1, 1, v);
  endtask

  initial begin
    logic [15:0] v;
    logic [7:0]  offs [6];
    logic [15:0] rst_exp [6];
    logic [7:0]  ra;
    logic [15:0] rd_;
    logic [1:0]  lanes;
    int          op;

    offs    = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A};
    rst_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};

    // Power-on reset
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_ack", {15'h0000, ack}, 16'h0000);
    chk("rst_irq", {15'h0000, irq}, 16'h0000);
    chk("rst_data_read", data_read, 16'h0000);
    idle(1);
    for (int i = 0; i < 6; i++) begin
      bus_rd(offs[i], v);
      chk("rst_reg", v, rst_exp[i]);
    end

    // Byte lanes on COMPARE
    access(1'b1, TMR_COMPARE, 16'h1234, 1'b1, 1'b0, 1, v);
    access(1'b1, TMR_COMPARE, 16'hAB56, 1'b0, 1'b1, 1, v);
    bus_rd(TMR_COMPARE, v);
    chk("lanes", v, 16'h1256);

    // Held write strobe commits only once while the counter keeps running
    bus_wr(TMR_PRESC, 16'h0000);
    bus_wr(TMR_CTRL, 16'h0001);
    access(1'b1, TMR_COUNT, 16'h0010, 1'b1, 1'b1, 5, v);
    bus_rd(TMR_COUNT, v);
    chk("hold_once", v, 16'h0015);
    bus_wr(TMR_CTRL, 16'h0000);

    // Prescaled count with autoreload and interrupt
    bus_wr(TMR_STATUS, 16'h0001);
    bus_wr(TMR_COUNT, 16'h0000);
    bus_wr(TMR_PRESC, 16'h0003);
    bus_wr(TMR_COMPARE, 16'h0005);
    bus_wr(TMR_CTRL, 16'h0007);
    idle(19);
    chk("irq_before_match", {15'h0000, irq}, 16'h0000);
    idle(1);
    chk("irq_after_match", {15'h0000, irq}, 16'h0001);
    bus_rd(TMR_COUNT, v);
    chk("autoreload_zero", v, 16'h0000);
    bus_rd(TMR_STATUS, v);
    chk("match_set", v, 16'h0001);
    bus_wr(TMR_STATUS, 16'h0001);
    chk("irq_cleared", {15'h0000, irq}, 16'h0000);

    // Wrap through 0xFFFF without autoreload
    bus_wr(TMR_CTRL, 16'h0000);
    bus_wr(TMR_STATUS, 16'h0001);
    bus_wr(TMR_PRESC, 16'h0000);
    bus_wr(TMR_COMPARE, 16'h0003);
    bus_wr(TMR_COUNT, 16'hFFFE);
    bus_wr(TMR_CTRL, 16'h0001);
    bus_rd(TMR_COUNT, v);
    chk("wrap_ffff", v, 16'hFFFF);
    bus_rd(TMR_COUNT, v);
    chk("wrap_0001", v, 16'h0001);
    bus_rd(TMR_COUNT, v);
    chk("wrap_0003", v, 16'h0003);
    bus_rd(TMR_STATUS, v);
    chk("wrap_match", v, 16'h0001);
    bus_rd(TMR_COUNT, v);
    chk("wrap_continue", v, 16'h0007);

    // STATUS clear on the match edge: set wins
    bus_wr(TMR_CTRL, 16'h0000);
    bus_wr(TMR_STATUS, 16'h0001);
    bus_wr(TMR_COMPARE, 16'h0010);
    bus_wr(TMR_COUNT, 16'h000E);
    bus_wr(TMR_CTRL, 16'h0001);
    bus_wr(TMR_STATUS, 16'h0001);
    bus_rd(TMR_STATUS, v);
    chk("clr_vs_set", v, 16'h0001);

    // COUNT write on a tick edge: bus value wins
    bus_wr(TMR_CTRL, 16'h0000);
    bus_wr(TMR_COUNT, 16'h0000);
    bus_wr(TMR_PRESC, 16'h0003);
    bus_wr(TMR_CTRL, 16'h0001);
    idle(2);
    bus_wr(TMR_COUNT, 16'h0100);
    bus_rd(TMR_COUNT, v);
    chk("count_vs_tick", v, 16'h0100);

    // Asynchronous reset in the middle of an acknowledged write
    bus_wr(TMR_CTRL, 16'h0002);
    idle(1);
    chk("irq_before_rst", {15'h0000, irq}, 16'h0001);
    addr = TMR_COMPARE; rw = 1'b0; data_write = 16'h5555; uds = 1'b1; lds = 1'b1;
    edge_step(1'b1, TMR_COMPARE, 16'h5555, 1'b1, 1'b1);
    chk("ack_before_rst", {15'h0000, ack}, 16'h0001);
    #2;
    reset_n = 1'b0;
    uds = 1'b0; lds = 1'b0;
    #1;
    chk("async_ack", {15'h0000, ack}, 16'h0000);
    chk("async_irq", {15'h0000, irq}, 16'h0000);
    chk("async_data_read", data_read, 16'h0000);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    for (int i = 0; i < 6; i++) begin
      bus_rd(offs[i], v);
      chk("post_rst_reg", v, rst_exp[i]);
    end

    // Random traffic against the model
    for (int k = 0; k < 60; k++) begin
      op    = int'($urandom_range(0, 3));
      ra    = 8'(2 * $urandom_range(0, 7)) | 8'($urandom_range(0, 1));
      lanes = 2'($urandom_range(1, 3));
      case ({ra[7:1], 1'b0})
        TMR_PRESC:   rd_ = 16'($urandom_range(0, 5));
        TMR_COUNT:   rd_ = 16'($urandom_range(0, 24));
        TMR_COMPARE: rd_ = 16'($urandom_range(0, 24));
        TMR_STATUS:  rd_ = 16'($urandom_range(0, 1));
        default:     rd_ = 16'($urandom);
      endcase
      access(op >= 2, ra, rd_, lanes[1], lanes[0], int'($urandom_range(1, 3)), v);
      idle(int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
